// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, fetch-sequencer state encodings and enable constants for if_fetch_ctrl.
package if_fetch_ctrl_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [2:0] IfIdle  = 3'd0;
  localparam logic [2:0] IfFetch = 3'd1;
  localparam logic [2:0] IfStep  = 3'd2;
  localparam logic [2:0] IfHold  = 3'd3;
  localparam logic [2:0] IfKill  = 3'd4;
  localparam logic [2:0] IfRedir = 3'd5;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

endpackage

// File: rtl/if_fetch_ctrl_wait_timer.sv
// Ack wait timer: down-counter reloaded on clear, flags expiry at terminal count zero.
module if_wait_timer #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] LOAD  = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i & ~clr_i & (cnt_q == '0);

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer between pc module, instruction memory and IF/ID.
// Define IF_TIMEOUT_EN to add the imem ack timeout with redirect to EXC_VECTOR.
//
//   state   | meaning
//   IfIdle  | out of reset, waiting one clock
//   IfFetch | req to imem at pc_i, waiting for ack
//   IfStep  | pc_en pulse, pc advances by 4
//   IfHold  | IF/ID stalled on a live instruction, no request
//   IfKill  | req overtaken by a branch, drain the ack and discard it
//   IfRedir | pc_en + branch_en pulse, pc loads the latched target
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int                     IMEM_TIMEOUT = 16,
  parameter logic [InstAddrBus-1:0] EXC_VECTOR   = 32'h0000_0040
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc_i,
  output logic                   pc_en_o,
  output logic                   branch_en_o,
  output logic [InstAddrBus-1:0] branch_o,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [InstBus-1:0]     imem_rdata_i,
  input  logic                   branch_en_i,
  input  logic [InstAddrBus-1:0] branch_addr_i,
  input  logic                   stall_i,
  output logic                   if_valid_o,
  output logic [InstBus-1:0]     if_inst_o,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic                   fetch_err_o
);

  logic [2:0]             state_q, state_d;
  logic [InstAddrBus-1:0] target_q, target_d;
  logic                   valid_q, valid_d;
  logic [InstBus-1:0]     inst_q, inst_d;
  logic [InstAddrBus-1:0] ipc_q, ipc_d;
  logic                   capture;
  logic                   timeout;

  if (IMEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("IMEM_TIMEOUT must be at least 2");
  end

`ifdef IF_TIMEOUT_EN
  localparam int TmrW = $clog2(IMEM_TIMEOUT);

  logic tmr_expired;
  logic err_q;

  if_wait_timer #(
    .WIDTH (TmrW),
    .LOAD  (TmrW'(IMEM_TIMEOUT - 1))
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (~imem_req_o | imem_ack_i),
    .en_i      (imem_req_o),
    .expired_o (tmr_expired)
  );

  // An ack arriving on the expiry cycle still completes the fetch.
  assign timeout = tmr_expired & ~imem_ack_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= Disable;
    end else begin
      err_q <= timeout;
    end
  end

  assign fetch_err_o = err_q;
`else
  assign timeout     = Disable;
  assign fetch_err_o = Disable;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    capture  = Disable;
    case (state_q)
      IfIdle: state_d = IfFetch;
      IfFetch: begin
        if (timeout) begin
          state_d = IfRedir;
        end else if (branch_en_i) begin
          target_d = branch_addr_i;
          state_d  = imem_ack_i ? IfRedir : IfKill;
        end else if (imem_ack_i) begin
          capture = Enable;
          state_d = IfStep;
        end
      end
      IfStep: begin
        if (branch_en_i) begin
          target_d = branch_addr_i;
          state_d  = IfRedir;
        end else if (valid_q && stall_i) begin
          state_d = IfHold;
        end else begin
          state_d = IfFetch;
        end
      end
      IfHold: begin
        if (branch_en_i) begin
          target_d = branch_addr_i;
          state_d  = IfRedir;
        end else if (!stall_i) begin
          state_d = IfFetch;
        end
      end
      IfKill: begin
        if (timeout) begin
          state_d = IfRedir;
        end else begin
          if (branch_en_i) begin
            target_d = branch_addr_i;
          end
          if (imem_ack_i) begin
            state_d = IfRedir;
          end
        end
      end
      IfRedir: begin
        // A branch landing on the redirect cycle re-redirects to the newer target.
        if (branch_en_i) begin
          target_d = branch_addr_i;
        end else begin
          state_d = IfFetch;
        end
      end
      default: state_d = IfIdle;
    endcase
    if (timeout) begin
      target_d = EXC_VECTOR;
    end
  end

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    if (branch_en_i || timeout) begin
      valid_d = Disable;
    end else if (capture) begin
      valid_d = Enable;
      inst_d  = imem_rdata_i;
      ipc_d   = pc_i;
    end else if (valid_q && !stall_i) begin
      valid_d = Disable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IfIdle;
      target_q <= '0;
      valid_q  <= Disable;
      inst_q   <= '0;
      ipc_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
    end
  end

  assign imem_req_o  = (state_q == IfFetch) || (state_q == IfKill);
  assign imem_addr_o = imem_req_o ? pc_i : '0;
  assign pc_en_o     = (state_q == IfStep) || (state_q == IfRedir);
  assign branch_en_o = (state_q == IfRedir);
  assign branch_o    = branch_en_o ? target_q : '0;
  assign if_valid_o  = valid_q;
  assign if_inst_o   = inst_q;
  assign if_pc_o     = ipc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: pc model, delayed-ack imem model, delivery scoreboard.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q = 32'h0;
  logic        pc_en_o, branch_en_o, imem_req_o, if_valid_o, fetch_err_o;
  logic [31:0] branch_o, imem_addr_o, if_inst_o, if_pc_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        branch_en_i = 1'b0;
  logic [31:0] branch_addr_i = 32'h0;
  logic        stall_i = 1'b0;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_q),
    .pc_en_o       (pc_en_o),
    .branch_en_o   (branch_en_o),
    .branch_o      (branch_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .branch_en_i   (branch_en_i),
    .branch_addr_i (branch_addr_i),
    .stall_i       (stall_i),
    .if_valid_o    (if_valid_o),
    .if_inst_o     (if_inst_o),
    .if_pc_o       (if_pc_o),
    .fetch_err_o   (fetch_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return 32'h2401_0001 + a;
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc_en"}, 32'(pc_en_o), 32'd0);
    chk({tag, "_br_en"}, 32'(branch_en_o), 32'd0);
    chk({tag, "_br"}, branch_o, 32'd0);
    chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
    chk({tag, "_addr"}, imem_addr_o, 32'd0);
    chk({tag, "_valid"}, 32'(if_valid_o), 32'd0);
    chk({tag, "_inst"}, if_inst_o, 32'd0);
    chk({tag, "_ifpc"}, if_pc_o, 32'd0);
    chk({tag, "_err"}, 32'(fetch_err_o), 32'd0);
  endtask

  // pc module model: resets synchronously so the address gating is visible under async reset
  always @(posedge clk) begin
    if (rst) pc_q <= 32'h0;
    else if (pc_en_o) pc_q <= branch_en_o ? branch_o : pc_q + 32'd4;
  end

  int          ack_dly = 0;
  int          wait_cnt = 0;
  int          drop_cnt = 0;
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    imem_ack_i   = imem_req_o && (wait_cnt >= ack_dly);
    imem_rdata_i = imem_ack_i ? inst_at(imem_addr_o) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (rst) begin
      wait_cnt = 0;
    end else if (imem_req_o && imem_ack_i) begin
      wait_cnt = 0;
      if (drop_cnt > 0) drop_cnt--;
      else exp_q.push_back({pc_q, inst_at(pc_q)});
    end else if (imem_req_o) begin
      wait_cnt++;
    end
  end

  logic        prev_valid = 1'b0;
  logic        err_seen = 1'b0;
  logic [31:0] last_pc = 32'h0;
  int          deliv = 0;

  always @(negedge clk) begin
    if (fetch_err_o) err_seen = 1'b1;
    if (if_valid_o && !prev_valid) begin
      deliv++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("deliv_pc", if_pc_o, e[63:32]);
        chk("deliv_inst", if_inst_o, e[31:0]);
        last_pc = e[63:32];
      end
    end
    prev_valid = if_valid_o;
  end

  initial begin
    logic [31:0] base;
    int pulses, reqs, d0, n;
    rst = 1'b1;
    repeat (3) cyc();
    chk_zero("rst");
    rst = 1'b0;

    cyc();
    chk("c1_req", 32'(imem_req_o), 32'd1);
    chk("c1_addr", imem_addr_o, 32'h0);
    chk("c1_valid", 32'(if_valid_o), 32'd0);
    cyc();
    chk("c2_valid", 32'(if_valid_o), 32'd1);
    chk("c2_ifpc", if_pc_o, 32'h0);
    chk("c2_inst", if_inst_o, 32'h2401_0001);
    chk("c2_pc_en", 32'(pc_en_o), 32'd1);
    chk("c2_req", 32'(imem_req_o), 32'd0);
    cyc();
    chk("c3_addr", imem_addr_o, 32'h4);
    cyc();
    cyc();
    chk("c5_addr", imem_addr_o, 32'h8);
    branch_en_i = 1'b1; branch_addr_i = 32'h200; drop_cnt = 1;
    cyc();
    branch_en_i = 1'b0;
    chk("brack_pc_en", 32'(pc_en_o), 32'd1);
    chk("brack_br_en", 32'(branch_en_o), 32'd1);
    chk("brack_br", branch_o, 32'h200);
    chk("brack_valid", 32'(if_valid_o), 32'd0);
    cyc();
    chk("brack_addr", imem_addr_o, 32'h200);

    for (int k = 0; k < 20 && !if_valid_o; k++) cyc();
    chk("stall_valid", 32'(if_valid_o), 32'd1);
    stall_i = 1'b1;
    base = last_pc;
    pulses = 0; reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      pulses += int'(pc_en_o);
      reqs += int'(imem_req_o);
      chk("stall_inst", if_inst_o, inst_at(base));
    end
    chk("stall_pulses", 32'(pulses), 32'd1);
    chk("stall_reqs", 32'(reqs), 32'd0);
    stall_i = 1'b0;
    ack_dly = 3;

    cyc();
    d0 = deliv;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      chk("dly_req", 32'(imem_req_o), 32'd1);
      chk("dly_addr", imem_addr_o, base + 32'd4);
    end
    cyc();
    chk("dly_one_capture", 32'(deliv - d0), 32'd1);
    ack_dly = 2;

    cyc();
    chk("kill_req0", 32'(imem_req_o), 32'd1);
    branch_en_i = 1'b1; branch_addr_i = 32'h100; drop_cnt = 1;
    cyc();
    branch_en_i = 1'b0;
    chk("kill_req1", 32'(imem_req_o), 32'd1);
    chk("kill_addr", imem_addr_o, base + 32'd8);
    chk("kill_valid", 32'(if_valid_o), 32'd0);
    cyc();
    chk("kill_req2", 32'(imem_req_o), 32'd1);
    cyc();
    chk("redir_pc_en", 32'(pc_en_o), 32'd1);
    chk("redir_br_en", 32'(branch_en_o), 32'd1);
    chk("redir_br", branch_o, 32'h100);
    chk("redir_valid", 32'(if_valid_o), 32'd0);
    ack_dly = 0;
    cyc();
    chk("redir_addr", imem_addr_o, 32'h100);
    cyc();
    ack_dly = 1000;

    cyc();
    chk("hang_req", 32'(imem_req_o), 32'd1);
    branch_en_i = 1'b1; branch_addr_i = 32'h300;
    cyc();
    branch_en_i = 1'b0;
    repeat (4) cyc();
    chk("hang_kill_req", 32'(imem_req_o), 32'd1);
    chk("hang_kill_addr", imem_addr_o, 32'h104);
    #2 rst = 1'b1;
    #1 chk_zero("rst_kill");
    repeat (3) cyc();

`ifdef IF_TIMEOUT_EN
    rst = 1'b0;
    n = 0;
    while (n < 40 && !fetch_err_o) begin
      cyc();
      n++;
    end
    chk("to_err", 32'(fetch_err_o), 32'd1);
    chk("to_cycle", 32'(n), 32'd17);
    chk("to_br", branch_o, 32'h40);
    cyc();
    chk("to_addr", imem_addr_o, 32'h40);
    chk("to_err_pulse", 32'(fetch_err_o), 32'd0);
`else
    n = 0;
    chk("no_err_seen", 32'(err_seen), 32'd0);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
